dmem_arbiter: RTL and testbench

Shares the single-port synchronous data memory between the MIPS CPU (load/store port driven from the datapath's memaddr/writedata) and the Mandelbrot pixel accelerator. Accepts at most one access per cycle, round-robin between the two requesters when both are eligible, and returns read data one cycle after issue. It produces a CPU stall signal that freezes the PC while a CPU load/store waits for its slot.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/sat_counter.sv | 29 ++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice.
// Contents:
//   owner_t         - encoding of who owns a memory access
//                     (OWN_NONE / OWN_CPU / OWN_ACC)
//   DEFAULT_ADDR_W  - default word-address width
//   DEFAULT_DATA_W  - default data width
//   DEFAULT_CNT_W   - default width of the conflict counter
package dmem_arbiter_pkg;

   localparam int DEFAULT_ADDR_W = 14;
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_CNT_W  = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_ACC  = 2'd2
   } owner_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; clears the count
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current count, WIDTH bits
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // The count only moves while it is below all-ones, so once it reaches
   // the top it stays there until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port synchronous data memory between the MIPS CPU
// load/store port and the Mandelbrot pixel accelerator. At most one access
// is issued per cycle; ties are broken round-robin. Read data returns one
// cycle after issue together with a one-cycle ready pulse.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      in    CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready       out   CPU completion and load data
//   cpu_stall                  out   CPU request still waiting
//   acc_req/we/addr/wdata      in    accelerator request, held until acc_ready
//   acc_rdata, acc_ready       out   accelerator completion and load data
//   mem_en/we/addr/wdata       out   memory command for this cycle
//   mem_rdata                  in    memory read data, cycle after mem_en
//   conflicts                  out   saturating count of tie cycles
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_stall,

   input  logic              acc_req,
   input  logic              acc_we,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   output logic [DATA_W-1:0] acc_rdata,
   output logic              acc_ready,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic [CNT_W-1:0]  conflicts
);

   owner_t inflight;
   owner_t inflightNext;
   owner_t lastGrant;
   owner_t lastGrantNext;
   owner_t grant;

   logic cpuEligible;
   logic accEligible;
   logic bothEligible;

   // Arbitration and memory command mux. A requester whose access is
   // completing this cycle still shows req high, so it is excluded until its
   // ready pulse is over. On a tie the requester that did not win last time
   // goes first. Only the granted requester's signals reach the memory; an
   // idle cycle drives all-zero command fields.
   always_comb begin
      grant         = OWN_NONE;
      mem_en        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      cpuEligible   = cpu_req && (inflight != OWN_CPU);
      accEligible   = acc_req && (inflight != OWN_ACC);
      bothEligible  = cpuEligible && accEligible;

      if (bothEligible) begin
         grant = (lastGrant == OWN_CPU) ? OWN_ACC : OWN_CPU;
      end else if (cpuEligible) begin
         grant = OWN_CPU;
      end else if (accEligible) begin
         grant = OWN_ACC;
      end

      case (grant)
         OWN_CPU: begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         OWN_ACC: begin
            mem_en    = 1'b1;
            mem_we    = acc_we;
            mem_addr  = acc_addr;
            mem_wdata = acc_wdata;
         end
         default: begin
         end
      endcase

      inflightNext  = grant;
      lastGrantNext = (grant == OWN_NONE) ? lastGrant : grant;
   end

   // Ownership registers. Reset abandons any access in flight (no ready
   // pulse follows) and points last-grant at the accelerator so the CPU
   // wins the first tie afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight  <= OWN_NONE;
         lastGrant <= OWN_ACC;
      end else begin
         inflight  <= inflightNext;
         lastGrant <= lastGrantNext;
      end
   end

   // Completion side. Whoever issued last cycle gets the ready pulse and the
   // memory's read data; the other side sees zero data. The CPU stalls for
   // as long as it is asking and has not been answered.
   always_comb begin
      cpu_ready = (inflight == OWN_CPU);
      acc_ready = (inflight == OWN_ACC);
      cpu_rdata = cpu_ready ? mem_rdata : '0;
      acc_rdata = acc_ready ? mem_rdata : '0;
      cpu_stall = cpu_req && !cpu_ready;
   end

   // Tie cycles are counted for performance tuning of the accelerator's
   // memory access pattern.
   sat_counter #(
      .WIDTH (CNT_W)
   ) u_conflict_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (bothEligible),
      .count (conflicts)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. Directed scenarios plus randomized
// traffic compared against a behavioural reference model of the sharing
// rules. A second instance with a narrow conflict counter shares the same
// stimulus so saturation can be observed in a short run.
module tb_dmem_arbiter;

   localparam int AW      = 14;
   localparam int DW      = 32;
   localparam int SMALL_W = 3;
   localparam int DEPTH   = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, acc_req, acc_we;
   logic [AW-1:0] cpu_addr, acc_addr;
   logic [DW-1:0] cpu_wdata, acc_wdata;
   logic [DW-1:0] cpu_rdata, acc_rdata;
   logic          cpu_ready, acc_ready, cpu_stall;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] memRdata;
   logic [15:0]   conflicts;

   logic [DW-1:0]      sCpuRdata, sAccRdata, sMemWdata;
   logic               sCpuReady, sAccReady, sCpuStall, sMemEn, sMemWe;
   logic [AW-1:0]      sMemAddr;
   logic [SMALL_W-1:0] sConflicts;

   logic [DW-1:0] memArr [0:DEPTH-1];
   logic [DW-1:0] refMem [0:DEPTH-1];

   int checks = 0;
   int errors = 0;

   // reference model state: who completes next cycle, who won last, ties seen
   int            busyWith;
   int            prevWinner;
   int            conflictTally;
   int            winner;
   logic          bothWaiting;
   logic [DW-1:0] cpuPendData, accPendData;
   logic          cpuPendWrite, accPendWrite;

   logic               expMemEn, expMemWe, expCpuReady, expAccReady, expStall;
   logic [AW-1:0]      expAddr;
   logic [DW-1:0]      expWdata;
   logic [15:0]        expConflicts;
   logic [SMALL_W-1:0] expSmall;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_stall (cpu_stall),
      .acc_req   (acc_req),
      .acc_we    (acc_we),
      .acc_addr  (acc_addr),
      .acc_wdata (acc_wdata),
      .acc_rdata (acc_rdata),
      .acc_ready (acc_ready),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (memRdata),
      .conflicts (conflicts)
   );

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(SMALL_W)) dutSmall (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (sCpuRdata),
      .cpu_ready (sCpuReady),
      .cpu_stall (sCpuStall),
      .acc_req   (acc_req),
      .acc_we    (acc_we),
      .acc_addr  (acc_addr),
      .acc_wdata (acc_wdata),
      .acc_rdata (sAccRdata),
      .acc_ready (sAccReady),
      .mem_en    (sMemEn),
      .mem_we    (sMemWe),
      .mem_addr  (sMemAddr),
      .mem_wdata (sMemWdata),
      .mem_rdata (memRdata),
      .conflicts (sConflicts)
   );

   // single-port synchronous memory, read-before-write
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) memArr[mem_addr] <= mem_wdata;
         memRdata <= memArr[mem_addr];
      end
   end

   task applyStimulus(input logic cReq, input logic cWe, input logic [AW-1:0] cAddr,
                      input logic [DW-1:0] cWdata, input logic aReq, input logic aWe,
                      input logic [AW-1:0] aAddr, input logic [DW-1:0] aWdata);
      cpu_req   = cReq;
      cpu_we    = cWe;
      cpu_addr  = cAddr;
      cpu_wdata = cWdata;
      acc_req   = aReq;
      acc_we    = aWe;
      acc_addr  = aAddr;
      acc_wdata = aWdata;
   endtask

   // leaves the bench 1 time unit after a rising edge with reset released
   task doReset(input int n);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task modelReset();
      busyWith      = 0;
      prevWinner    = 2;
      conflictTally = 0;
      cpuPendWrite  = 1'b0;
      accPendWrite  = 1'b0;
      cpuPendData   = '0;
      accPendData   = '0;
      for (int i = 0; i < DEPTH; i++) refMem[i] = memArr[i];
   endtask

   // what the sharing rules say should be visible during the current cycle
   task predict();
      logic cpuWaiting, accWaiting;
      cpuWaiting  = cpu_req && (busyWith != 1);
      accWaiting  = acc_req && (busyWith != 2);
      bothWaiting = cpuWaiting && accWaiting;
      if (bothWaiting)     winner = (prevWinner == 1) ? 2 : 1;
      else if (cpuWaiting) winner = 1;
      else if (accWaiting) winner = 2;
      else                 winner = 0;
      expMemEn = (winner != 0);
      expMemWe = (winner == 1) ? cpu_we : (winner == 2) ? acc_we : 1'b0;
      expAddr  = (winner == 1) ? cpu_addr : (winner == 2) ? acc_addr : '0;
      expWdata = (winner == 1) ? cpu_wdata : (winner == 2) ? acc_wdata : '0;
      expCpuReady  = (busyWith == 1);
      expAccReady  = (busyWith == 2);
      expStall     = cpu_req && !expCpuReady;
      expConflicts = (conflictTally > 65535) ? 16'hFFFF : conflictTally[15:0];
      expSmall     = (conflictTally > 7) ? 3'd7 : conflictTally[2:0];
   endtask

   // called right after the rising edge, before inputs move
   task commitModel();
      if (winner == 1) begin
         cpuPendWrite = cpu_we;
         if (cpu_we) refMem[cpu_addr] = cpu_wdata;
         else        cpuPendData = refMem[cpu_addr];
      end else if (winner == 2) begin
         accPendWrite = acc_we;
         if (acc_we) refMem[acc_addr] = acc_wdata;
         else        accPendData = refMem[acc_addr];
      end
      if (reset) begin
         busyWith      = 0;
         prevWinner    = 2;
         conflictTally = 0;
      end else begin
         if (bothWaiting) conflictTally++;
         busyWith = winner;
         if (winner != 0) prevWinner = winner;
      end
   endtask

   task pickCpu();
      cpu_req   = 1'b1;
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = AW'($urandom_range(0, 31));
      cpu_wdata = $urandom;
   endtask

   task pickAcc();
      acc_req   = 1'b1;
      acc_we    = 1'($urandom_range(0, 1));
      acc_addr  = AW'($urandom_range(0, 31));
      acc_wdata = $urandom;
   endtask

   task test_reset();
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({cpu_ready, acc_ready} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_ready: got %b required 00", {cpu_ready, acc_ready});
      end
      checks++;
      if (cpu_stall !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_stall_follows_req: got %b required 1", cpu_stall);
      end
      checks++;
      if (conflicts !== 16'h0) begin
         errors++; $display("[TB] FAIL reset_conflicts: got %h required 0000", conflicts);
      end
      checks++;
      if ({cpu_rdata, acc_rdata} !== 64'h0) begin
         errors++; $display("[TB] FAIL reset_rdata: got %h required 0", {cpu_rdata, acc_rdata});
      end
      doReset(1);
   endtask

   task test_cpu_load();
      doReset(2);
      memArr[14'h010] = 32'hDEADBEEF;
      applyStimulus(1'b1, 1'b0, 14'h010, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if ({mem_en, mem_we, mem_addr, cpu_stall, cpu_ready} !== {1'b1, 1'b0, 14'h010, 1'b1, 1'b0}) begin
         errors++; $display("[TB] FAIL load_issue: got en=%b we=%b addr=%h stall=%b rdy=%b required 1 0 0010 1 0",
                            mem_en, mem_we, mem_addr, cpu_stall, cpu_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({cpu_ready, cpu_stall, mem_en} !== 3'b100) begin
         errors++; $display("[TB] FAIL load_complete: got rdy=%b stall=%b en=%b required 1 0 0", cpu_ready, cpu_stall, mem_en);
      end
      checks++;
      if (cpu_rdata !== 32'hDEADBEEF) begin
         errors++; $display("[TB] FAIL load_rdata: got %h required DEADBEEF", cpu_rdata);
      end
      @(posedge clk); #1 cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_ready, cpu_stall, cpu_rdata} !== {1'b0, 1'b0, 32'h0}) begin
         errors++; $display("[TB] FAIL load_idle: got rdy=%b stall=%b rdata=%h required 0 0 0", cpu_ready, cpu_stall, cpu_rdata);
      end
   endtask

   task test_tie_from_reset();
      doReset(2);
      memArr[14'h0100] = 32'hA5A50100;
      applyStimulus(1'b1, 1'b1, 14'h0005, 32'h1, 1'b1, 1'b0, 14'h0100, '0);
      @(negedge clk);
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 14'h0005, 32'h1}) begin
         errors++; $display("[TB] FAIL tie_cycle0: got en=%b we=%b addr=%h wdata=%h required 1 1 0005 00000001",
                            mem_en, mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({cpu_ready, acc_ready, mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 14'h0100}) begin
         errors++; $display("[TB] FAIL tie_cycle1: got crdy=%b ardy=%b en=%b we=%b addr=%h required 1 0 1 0 0100",
                            cpu_ready, acc_ready, mem_en, mem_we, mem_addr);
      end
      @(posedge clk); #1 cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({acc_ready, acc_rdata, mem_en} !== {1'b1, 32'hA5A50100, 1'b0}) begin
         errors++; $display("[TB] FAIL tie_cycle2: got rdy=%b rdata=%h en=%b required 1 A5A50100 0", acc_ready, acc_rdata, mem_en);
      end
      checks++;
      if (conflicts !== 16'd1) begin
         errors++; $display("[TB] FAIL tie_conflicts: got %0d required 1", conflicts);
      end
      @(posedge clk); #1 acc_req = 1'b0;
      @(negedge clk);
      checks++;
      if (memArr[14'h0005] !== 32'h1) begin
         errors++; $display("[TB] FAIL tie_store_landed: got %h required 00000001", memArr[14'h0005]);
      end
   endtask

   task test_back_to_back();
      int idleCycles;
      doReset(2);
      modelReset();
      idleCycles = 0;
      pickCpu();
      pickAcc();
      for (int c = 0; c < 20; c++) begin
         logic cSaw, aSaw;
         @(negedge clk);
         predict();
         if (mem_en !== 1'b1) idleCycles++;
         checks++;
         if ({mem_en, mem_addr, mem_we} !== {expMemEn, expAddr, expMemWe}) begin
            errors++; $display("[TB] FAIL b2b_issue cycle %0d: got en=%b addr=%h we=%b required %b %h %b",
                               c, mem_en, mem_addr, mem_we, expMemEn, expAddr, expMemWe);
         end
         checks++;
         if ({cpu_ready, acc_ready, conflicts} !== {expCpuReady, expAccReady, expConflicts}) begin
            errors++; $display("[TB] FAIL b2b_ready cycle %0d: got crdy=%b ardy=%b conf=%0d required %b %b %0d",
                               c, cpu_ready, acc_ready, conflicts, expCpuReady, expAccReady, expConflicts);
         end
         cSaw = cpu_ready;
         aSaw = acc_ready;
         @(posedge clk);
         commitModel();
         #1;
         if (cSaw) pickCpu();
         if (aSaw) pickAcc();
      end
      checks++;
      if (idleCycles !== 0) begin
         errors++; $display("[TB] FAIL b2b_utilisation: got %0d idle cycles required 0", idleCycles);
      end
      checks++;
      if (conflicts !== 16'd1) begin
         errors++; $display("[TB] FAIL b2b_conflicts_total: got %0d required 1", conflicts);
      end
      doReset(1);
   endtask

   task test_acc_stream();
      int readyCount, enCount;
      doReset(2);
      readyCount = 0;
      enCount    = 0;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'h0040, '0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (mem_en) enCount++;
         if (acc_ready) readyCount++;
         checks++;
         if ({mem_en, acc_ready} !== {(i % 2 == 0), (i % 2 == 1)}) begin
            errors++; $display("[TB] FAIL stream_phase cycle %0d: got en=%b rdy=%b required %b %b",
                               i, mem_en, acc_ready, (i % 2 == 0), (i % 2 == 1));
         end
         if (i % 2 == 1) begin
            checks++;
            if (acc_rdata !== memArr[14'h0040 + AW'(i / 2)]) begin
               errors++; $display("[TB] FAIL stream_rdata cycle %0d: got %h required %h",
                                  i, acc_rdata, memArr[14'h0040 + AW'(i / 2)]);
            end
         end
         checks++;
         if ({cpu_ready, cpu_stall, cpu_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            errors++; $display("[TB] FAIL stream_cpu_quiet cycle %0d: got rdy=%b stall=%b rdata=%h required 0 0 0",
                               i, cpu_ready, cpu_stall, cpu_rdata);
         end
         @(posedge clk); #1;
         if (i % 2 == 1) begin
            if (i / 2 + 1 == 8) acc_req = 1'b0;
            else acc_addr = 14'h0040 + AW'(i / 2 + 1);
         end
      end
      checks++;
      if ({readyCount, enCount} !== {32'd8, 32'd8}) begin
         errors++; $display("[TB] FAIL stream_counts: got ready=%0d en=%0d required 8 8", readyCount, enCount);
      end
   endtask

   task test_reset_mid_access();
      doReset(2);
      applyStimulus(1'b1, 1'b0, 14'h0010, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_issue: got en=%b required 1", mem_en);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({cpu_ready, cpu_rdata} !== {1'b0, 32'h0}) begin
         errors++; $display("[TB] FAIL midrst_no_ready: got rdy=%b rdata=%h required 0 0", cpu_ready, cpu_rdata);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 14'h0020, '0, 1'b1, 1'b0, 14'h0030, '0);
      @(negedge clk);
      checks++;
      if ({mem_addr, conflicts} !== {14'h0020, 16'd0}) begin
         errors++; $display("[TB] FAIL midrst_tie_cpu_first: got addr=%h conf=%0d required 0020 0", mem_addr, conflicts);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({cpu_ready, mem_addr, conflicts} !== {1'b1, 14'h0030, 16'd1}) begin
         errors++; $display("[TB] FAIL midrst_tie_acc_next: got rdy=%b addr=%h conf=%0d required 1 0030 1",
                            cpu_ready, mem_addr, conflicts);
      end
      @(posedge clk); #1 cpu_req = 1'b0;
      @(posedge clk); #1 acc_req = 1'b0;
   endtask

   task test_saturation();
      doReset(2);
      for (int k = 0; k < 12; k++) begin
         pickCpu();
         pickAcc();
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if ({conflicts, sConflicts} !== {16'(k + 1), SMALL_W'((k + 1 > 7) ? 7 : k + 1)}) begin
            errors++; $display("[TB] FAIL sat_count iter %0d: got wide=%0d narrow=%0d required %0d %0d",
                               k, conflicts, sConflicts, k + 1, (k + 1 > 7) ? 7 : k + 1);
         end
         @(posedge clk); #1 cpu_req = 1'b0;
         @(posedge clk); #1 acc_req = 1'b0;
      end
   endtask

   task test_random_traffic();
      doReset(2);
      modelReset();
      for (int c = 0; c < 400; c++) begin
         logic cSaw, aSaw;
         @(negedge clk);
         predict();
         checks++;
         if ({mem_en, mem_we, mem_addr, mem_wdata} !== {expMemEn, expMemWe, expAddr, expWdata}) begin
            errors++; $display("[TB] FAIL rnd_mem cycle %0d: got en=%b we=%b addr=%h wdata=%h required %b %b %h %h",
                               c, mem_en, mem_we, mem_addr, mem_wdata, expMemEn, expMemWe, expAddr, expWdata);
         end
         checks++;
         if ({cpu_ready, acc_ready, cpu_stall} !== {expCpuReady, expAccReady, expStall}) begin
            errors++; $display("[TB] FAIL rnd_ready cycle %0d: got crdy=%b ardy=%b stall=%b required %b %b %b",
                               c, cpu_ready, acc_ready, cpu_stall, expCpuReady, expAccReady, expStall);
         end
         if (!(expCpuReady && cpuPendWrite)) begin
            checks++;
            if (cpu_rdata !== (expCpuReady ? cpuPendData : 32'h0)) begin
               errors++; $display("[TB] FAIL rnd_cpu_rdata cycle %0d: got %h required %h",
                                  c, cpu_rdata, expCpuReady ? cpuPendData : 32'h0);
            end
         end
         if (!(expAccReady && accPendWrite)) begin
            checks++;
            if (acc_rdata !== (expAccReady ? accPendData : 32'h0)) begin
               errors++; $display("[TB] FAIL rnd_acc_rdata cycle %0d: got %h required %h",
                                  c, acc_rdata, expAccReady ? accPendData : 32'h0);
            end
         end
         checks++;
         if ({conflicts, sConflicts, sMemEn} !== {expConflicts, expSmall, expMemEn}) begin
            errors++; $display("[TB] FAIL rnd_conflicts cycle %0d: got wide=%0d narrow=%0d en=%b required %0d %0d %b",
                               c, conflicts, sConflicts, sMemEn, expConflicts, expSmall, expMemEn);
         end
         cSaw = cpu_ready;
         aSaw = acc_ready;
         @(posedge clk);
         commitModel();
         #1;
         if (cSaw || !cpu_req) begin
            if ($urandom_range(0, 2) != 0) pickCpu();
            else cpu_req = 1'b0;
         end
         if (aSaw || !acc_req) begin
            if ($urandom_range(0, 2) != 0) pickAcc();
            else acc_req = 1'b0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) memArr[i] = $urandom;
      $display("[TB] starting dmem_arbiter bench");
      test_reset();
      test_cpu_load();
      test_tie_from_reset();
      test_back_to_back();
      test_acc_stream();
      test_reset_mid_access();
      test_saturation();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
